tt_um_divider_hhrb98: RTL and testbench

//  Sequential restoring divider: 8-bit dividend / 4-bit divisor -> 8-bit quotient + 4-bit remainder.

---
 rtl/div_pkg.sv | 14 +
 rtl/div_step.sv | 33 +++
 rtl/tt_um_divider_hhrb98.sv | 117 +++++++++++
 tb/tb_tt_um_divider_hhrb98.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared widths and state encoding for the restoring divider tile.
package div_pkg;

  localparam int DW    = 8;               // dividend / quotient width
  localparam int VW    = 4;               // divisor / remainder width
  localparam int CNT_W = $clog2(DW + 1);  // step counter width

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, then try the subtract.
module div_step
  import div_pkg::*;
(
  input  logic [VW:0]   rem_i,
  input  logic          next_bit_i,
  input  logic [VW-1:0] dvs_i,
  output logic [VW:0]   rem_next_o,
  output logic          q_bit_o
);

  logic [VW:0]   shifted;
  logic [VW+1:0] diff;
  logic          unused_rem_msb;

  // The partial remainder is always below the divisor, so its top bit never carries
  // information into the shift.
  assign unused_rem_msb = rem_i[VW];

  // Trial subtract one bit wider than the shifted remainder; its MSB is the borrow.
  always_comb begin
    shifted = {rem_i[VW-1:0], next_bit_i};
    diff    = {1'b0, shifted} - {2'b00, dvs_i};
    if (!diff[VW+1]) begin
      rem_next_o = diff[VW:0];
      q_bit_o    = 1'b1;
    end else begin
      rem_next_o = shifted;
      q_bit_o    = 1'b0;
    end
  end

endmodule

// File: rtl/tt_um_divider_hhrb98.sv
// Tiny Tapeout tile: sequential 8-bit / 4-bit restoring divider, one quotient bit per clock.
//
// state | meaning
// IDLE  | waiting for the first start after reset
// CALC  | shifting out one quotient bit per enabled edge (busy)
// DONE  | result held; done_q=0 here only on the cycle after a divide-by-zero capture
module tt_um_divider_hhrb98
  import div_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  div_state_t       state_q, state_d;
  logic [DW-1:0]    quo_q, quo_d;
  logic [VW:0]      rem_q, rem_d;
  logic [VW-1:0]    dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  logic             start;
  logic             rsel;
  logic             accept;
  logic [VW:0]      step_rem;
  logic             step_bit;
  logic             unused_uio;

  assign start      = uio_in[4];
  assign rsel       = uio_in[5];
  assign unused_uio = &{1'b0, uio_in[7:6]};

  // A new operation is accepted from IDLE, or from DONE once the result is visible.
  assign accept = ena && start &&
                  ((state_q == IDLE) || ((state_q == DONE) && done_q));

  div_step u_step (
    .rem_i      (rem_q),
    .next_bit_i (quo_q[DW-1]),
    .dvs_i      (dvs_q),
    .rem_next_o (step_rem),
    .q_bit_o    (step_bit)
  );

  // Next-state and datapath updates; everything holds when ena is low.
  always_comb begin
    state_d = state_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    done_d  = done_q;

    if (accept) begin
      quo_d   = ui_in;
      dvs_d   = uio_in[VW-1:0];
      rem_d   = '0;
      cnt_d   = '0;
      done_d  = 1'b0;
      state_d = (uio_in[VW-1:0] == '0) ? DONE : CALC;
    end else if (ena) begin
      unique case (state_q)
        IDLE: ;
        CALC: begin
          quo_d = {quo_q[DW-2:0], step_bit};
          rem_d = step_rem;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DW - 1)) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
        DONE: begin
          // Divide-by-zero lands here with done_q low; publish the saturated result.
          if (!done_q) begin
            quo_d  = '1;
            rem_d  = {1'b0, {VW{1'b1}}};
            done_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Output mux and handshake pins.
  always_comb begin
    uo_out  = rsel ? {{(8 - VW){1'b0}}, rem_q[VW-1:0]} : quo_q;
    uio_out = {done_q, (state_q == CALC), 6'b00_0000};
    uio_oe  = 8'b1100_0000;
  end

endmodule

// File: tb/tb_tt_um_divider_hhrb98.sv
// Self-checking bench for the divider tile: behavioural model plus directed and random stimulus.
module tb_tt_um_divider_hhrb98;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int total = 0;
  int bad   = 0;

  tt_um_divider_hhrb98 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: an operation is "left" cycles from completion; results come from / and %.
  logic       m_busy;
  logic       m_done;
  int         m_left;
  logic [7:0] m_q;
  logic [3:0] m_r;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_left <= 0;
      m_q    <= 8'd0;
      m_r    <= 4'd0;
    end else if (ena) begin
      if (uio_in[4] && m_left == 0) begin
        m_done <= 1'b0;
        if (uio_in[3:0] == 4'd0) begin
          m_q    <= 8'hFF;
          m_r    <= 4'hF;
          m_left <= 1;
          m_busy <= 1'b0;
        end else begin
          m_q    <= 8'(int'(ui_in) / int'(uio_in[3:0]));
          m_r    <= 4'(int'(ui_in) % int'(uio_in[3:0]));
          m_left <= 8;
          m_busy <= 1'b1;
        end
      end else if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
        end
      end
    end
  end

  // Compare the DUT with the model every cycle, away from the active edge.
  always @(negedge clk) begin
    chk("busy", int'(uio_out[6]), int'(m_busy));
    chk("done", int'(uio_out[7]), int'(m_done));
    chk("uio_out_low", int'(uio_out[5:0]), 0);
    chk("uio_oe", int'(uio_oe), 8'hC0);
    if (m_left == 0)
      chk("uo_out", int'(uo_out), uio_in[5] ? int'(m_r) : int'(m_q));
  end

  // Issue one division (caller is just after a posedge) and wait for done.
  task automatic run_op(input logic [7:0] a, input logic [3:0] b, input int freeze_at,
                        output int cyc, output logic busy_e,
                        output logic [7:0] q, output logic [3:0] r);
    ui_in  = a;
    uio_in = {4'b0001, b};
    @(posedge clk);
    #1;
    uio_in[4] = 1'b0;
    busy_e    = uio_out[6];
    cyc       = 0;
    while (cyc < 40) begin
      @(posedge clk);
      cyc++;
      #1;
      if (freeze_at != 0) begin
        if (cyc == freeze_at)     ena = 1'b0;
        if (cyc == freeze_at + 3) ena = 1'b1;
      end
      if (uio_out[7]) break;
    end
    if (!uio_out[7]) chk("done_timeout", 0, 1);
    q         = uo_out;
    uio_in[5] = 1'b1;
    #1;
    r         = uo_out[3:0];
    uio_in[5] = 1'b0;
  endtask

  int         cyc;
  logic       busy_e;
  logic [7:0] q;
  logic [3:0] r;
  int         n;

  initial begin
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'd0;
    uio_in = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_uo_out", int'(uo_out), 0);
    chk("rst_busy", int'(uio_out[6]), 0);
    chk("rst_done", int'(uio_out[7]), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 200 / 13
    run_op(8'd200, 4'd13, 0, cyc, busy_e, q, r);
    chk("t1_latency", cyc, 8);
    chk("t1_busy_at_start", int'(busy_e), 1);
    chk("t1_quo", int'(q), 8'h0F);
    chk("t1_rem", int'(r), 5);

    run_op(8'd255, 4'd1, 0, cyc, busy_e, q, r);
    chk("t2_quo_255", int'(q), 255);
    chk("t2_rem_255", int'(r), 0);
    run_op(8'd7, 4'd9, 0, cyc, busy_e, q, r);
    chk("t2_quo_7", int'(q), 0);
    chk("t2_rem_7", int'(r), 7);

    // Divide by zero
    run_op(8'd100, 4'd0, 0, cyc, busy_e, q, r);
    chk("t3_latency", cyc, 1);
    chk("t3_busy", int'(busy_e), 0);
    chk("t3_quo", int'(q), 8'hFF);
    chk("t3_rem", int'(r), 4'hF);

    // Start and operand changes mid-CALC are ignored
    ui_in  = 8'd200;
    uio_in = 8'h1D;
    @(posedge clk);
    #1;
    uio_in = 8'h0D;
    repeat (3) @(posedge clk);
    #1;
    ui_in  = 8'd50;
    uio_in = 8'h13;
    @(posedge clk);
    #1;
    uio_in = 8'h03;
    n = 0;
    while (!uio_out[7] && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("t4_done_seen", int'(uio_out[7]), 1);
    chk("t4_quo", int'(uo_out), 8'h0F);
    uio_in[5] = 1'b1;
    #1;
    chk("t4_rem", int'(uo_out), 5);
    uio_in[5] = 1'b0;

    // Reset in the middle of CALC
    ui_in  = 8'd200;
    uio_in = 8'h1D;
    @(posedge clk);
    #1;
    uio_in = 8'h0D;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t4_rst_busy", int'(uio_out[6]), 0);
    chk("t4_rst_done", int'(uio_out[7]), 0);
    chk("t4_rst_uo", int'(uo_out), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("t4_no_resume", int'(uio_out[7]), 0);

    // ena low for three edges mid-CALC
    run_op(8'd200, 4'd13, 2, cyc, busy_e, q, r);
    chk("t5_latency", cyc, 11);
    chk("t5_quo", int'(q), 8'h0F);
    chk("t5_rem", int'(r), 5);

    // Exhaustive sweep, back-to-back from DONE
    for (int a = 0; a < 256; a++) begin
      for (int b = 1; b < 16; b++) begin
        run_op(8'(a), 4'(b), 0, cyc, busy_e, q, r);
        chk("sweep_recon", int'(q) * b + int'(r), a);
        chk("sweep_rem_lt", int'(int'(r) < b), 1);
      end
    end

    // Products of the 4x4 multiplier divide back exactly
    for (int a = 1; a < 16; a++) begin
      for (int b = 1; b < 16; b++) begin
        run_op(8'(a * b), 4'(b), 0, cyc, busy_e, q, r);
        chk("mul_inv_quo", int'(q), a);
        chk("mul_inv_rem", int'(r), 0);
      end
    end

    // Randomized traffic: starts at any time, ena gaps, rsel toggling, zero divisors
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      #1;
      ena    = ($urandom_range(0, 9) != 0);
      ui_in  = 8'($urandom);
      uio_in = {2'b00, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                4'($urandom_range(0, 15))};
    end
    ena    = 1'b1;
    uio_in = 8'd0;
    repeat (20) @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
